// File: rtl/usb_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// usb_tx_serializer : SYNC + LSB-first byte serializer with USB bit stuffing
// Revision: 1.0
// ============================================================================
module usb_tx_serializer #(
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter int unsigned IFG_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       out_valid,
  output logic       tx_busy,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_STUFF = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             cur_last_q, cur_last_d;
  logic             cur_sync_q, cur_sync_d;
  logic [2:0]       ones_cnt_q, ones_cnt_d;
  logic             last_seen_q, last_seen_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             serial_out_q, serial_out_d;
  logic             out_valid_q, out_valid_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_error_q, tx_error_d;

  logic       accept;
  logic       pull;
  logic       bypass;
  logic       emit_en;
  logic       emit_val;
  logic [7:0] next_byte;
  logic       next_last;

  assign tx_ready = rst & ~hold_full_q & ~last_seen_q & (state_q != ST_GAP);
  assign accept   = tx_valid & tx_ready;

  // A byte arriving exactly at an empty-hold boundary goes straight to the shifter
  assign next_byte = hold_full_q ? hold_data_q : tx_data;
  assign next_last = hold_full_q ? hold_last_q : tx_last;

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    cur_last_d   = cur_last_q;
    cur_sync_d   = cur_sync_q;
    ones_cnt_d   = ones_cnt_q;
    last_seen_d  = last_seen_q;
    gap_cnt_d    = gap_cnt_q;
    serial_out_d = 1'b0;
    out_valid_d  = 1'b0;
    tx_error_d   = 1'b0;
    pull         = 1'b0;
    bypass       = 1'b0;
    emit_en      = 1'b0;
    emit_val     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SYNC;
          cur_sync_d = 1'b1;
          cur_last_d = 1'b0;
          bit_idx_d  = 3'd0;
          shift_d    = SYNC_PATTERN >> 1;
          emit_en    = 1'b1;
          emit_val   = SYNC_PATTERN[0];
        end
      end

      ST_SYNC, ST_DATA, ST_STUFF: begin
        if (ones_cnt_q == 3'd6) begin
          // shifter and bit index freeze while the stuff bit goes out
          state_d  = ST_STUFF;
          emit_en  = 1'b1;
          emit_val = 1'b0;
        end else if (bit_idx_q != 3'd7) begin
          state_d   = cur_sync_q ? ST_SYNC : ST_DATA;
          bit_idx_d = bit_idx_q + 3'd1;
          shift_d   = shift_q >> 1;
          emit_en   = 1'b1;
          emit_val  = shift_q[0];
        end else if (cur_last_q) begin
          state_d     = ST_GAP;
          gap_cnt_d   = GAP_LOAD;
          last_seen_d = 1'b0;
        end else if (hold_full_q || accept) begin
          pull       = hold_full_q;
          bypass     = ~hold_full_q;
          state_d    = ST_DATA;
          cur_sync_d = 1'b0;
          cur_last_d = next_last;
          bit_idx_d  = 3'd0;
          shift_d    = next_byte >> 1;
          emit_en    = 1'b1;
          emit_val   = next_byte[0];
        end else begin
          state_d     = ST_GAP;
          gap_cnt_d   = GAP_LOAD;
          last_seen_d = 1'b0;
          tx_error_d  = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (emit_en) begin
      serial_out_d = emit_val;
      out_valid_d  = 1'b1;
      ones_cnt_d   = emit_val ? (ones_cnt_q + 3'd1) : 3'd0;
    end else begin
      ones_cnt_d   = 3'd0;
    end

    // drain before refill so a same-edge pull and load leave the hold full
    if (pull) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      if (tx_last) begin
        last_seen_d = 1'b1;
      end
      if (!bypass) begin
        hold_data_d = tx_data;
        hold_last_d = tx_last;
        hold_full_d = 1'b1;
      end
    end

    tx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hold_data_q  <= 8'h00;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_q      <= 8'h00;
      bit_idx_q    <= 3'd0;
      cur_last_q   <= 1'b0;
      cur_sync_q   <= 1'b0;
      ones_cnt_q   <= 3'd0;
      last_seen_q  <= 1'b0;
      gap_cnt_q    <= '0;
      serial_out_q <= 1'b0;
      out_valid_q  <= 1'b0;
      tx_busy_q    <= 1'b0;
      tx_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      cur_last_q   <= cur_last_d;
      cur_sync_q   <= cur_sync_d;
      ones_cnt_q   <= ones_cnt_d;
      last_seen_q  <= last_seen_d;
      gap_cnt_q    <= gap_cnt_d;
      serial_out_q <= serial_out_d;
      out_valid_q  <= out_valid_d;
      tx_busy_q    <= tx_busy_d;
      tx_error_q   <= tx_error_d;
    end
  end

  assign serial_out = serial_out_q;
  assign out_valid  = out_valid_q;
  assign tx_busy    = tx_busy_q;
  assign tx_error   = tx_error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_usb_tx_serializer : directed packets checked cycle-by-cycle against a
// bit-stream model (SYNC + LSB-first bytes, stuff after six ones, idle gap).
module tb_usb_tx_serializer;

  localparam int IFG = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       serial_out;
  logic       out_valid;
  logic       tx_busy;
  logic       tx_error;

  usb_tx_serializer #(
    .SYNC_PATTERN(8'h80),
    .IFG_CYCLES  (IFG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .serial_out(serial_out),
    .out_valid (out_valid),
    .tx_busy   (tx_busy),
    .tx_error  (tx_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] pkt[$];
  logic exp_ov[64];
  logic exp_so[64];
  logic exp_busy[64];
  logic exp_err[64];
  logic exp_rchk[64];
  logic exp_rdy[64];
  int   exp_len = 0;
  int   tcyc = 0;
  bit   chk_on = 1'b0;
  logic [63:0] cap;
  int   cap_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: flatten SYNC + bytes into a bit list, then insert a 0 after every run of six 1s.
  task automatic build(input bit last_final);
    bit bits[$];
    int ones = 0;
    int L;
    logic [7:0] b;
    for (int k = -1; k < pkt.size(); k++) begin
      b = (k < 0) ? 8'h80 : pkt[k];
      for (int i = 0; i < 8; i++) begin
        bits.push_back(b[i]);
        if (b[i]) begin
          ones++;
          if (ones == 6) begin
            bits.push_back(1'b0);
            ones = 0;
          end
        end else begin
          ones = 0;
        end
      end
    end
    L = bits.size();
    exp_len = L + IFG + 1;
    for (int t = 0; t < 64; t++) begin
      exp_ov[t] = 0; exp_so[t] = 0; exp_busy[t] = 0;
      exp_err[t] = 0; exp_rchk[t] = 0; exp_rdy[t] = 0;
    end
    exp_rchk[0] = 1; exp_rdy[0] = 1;
    for (int t = 1; t <= L; t++) begin
      exp_ov[t] = 1; exp_so[t] = bits[t-1]; exp_busy[t] = 1;
    end
    for (int t = L + 1; t <= L + IFG; t++) begin
      exp_busy[t] = 1; exp_rchk[t] = 1; exp_rdy[t] = 0;
      exp_err[t]  = (t == L + 1) && !last_final;
    end
    exp_rchk[exp_len] = 1; exp_rdy[exp_len] = 1;
  endtask

  always @(negedge clk) begin
    if (chk_on && tcyc <= exp_len) begin
      check($sformatf("out_valid t=%0d", tcyc), out_valid, exp_ov[tcyc]);
      if (exp_ov[tcyc])
        check($sformatf("serial_out t=%0d", tcyc), serial_out, exp_so[tcyc]);
      check($sformatf("tx_busy t=%0d", tcyc), tx_busy, exp_busy[tcyc]);
      check($sformatf("tx_error t=%0d", tcyc), tx_error, exp_err[tcyc]);
      if (exp_rchk[tcyc])
        check($sformatf("tx_ready t=%0d", tcyc), tx_ready, exp_rdy[tcyc]);
      if (out_valid && cap_len < 64) begin
        cap[cap_len] = serial_out;
        cap_len++;
      end
      tcyc++;
    end
  end

  task automatic run_pkt(input bit last_final, input string tag);
    int idx = 0;
    int acc_cnt = 0;
    bit acc;
    build(last_final);
    @(posedge clk); #1;
    cap = '0; cap_len = 0; tcyc = 0; chk_on = 1'b1;
    tx_valid = 1'b1;
    tx_data  = pkt[0];
    tx_last  = (pkt.size() == 1) && last_final;
    for (int c = 0; c <= exp_len; c++) begin
      @(negedge clk); #2;
      acc = tx_valid & tx_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_cnt++;
        idx++;
        if (idx < pkt.size()) begin
          tx_data = pkt[idx];
          tx_last = (idx == pkt.size() - 1) && last_final;
        end else begin
          tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
        end
      end
    end
    chk_on = 1'b0;
    check({tag, " accepts"}, acc_cnt, pkt.size());
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset serial_out", serial_out, 1'b0);
    check("reset tx_busy", tx_busy, 1'b0);
    check("reset tx_error", tx_error, 1'b0);
    check("reset tx_ready", tx_ready, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("idle tx_ready", tx_ready, 1'b1);

    pkt = {8'hA5};
    run_pkt(1'b1, "A5");
    check("A5 bit count", cap_len, 16);
    check("A5 stream", cap[31:0], 32'h0000A580);

    pkt = {8'hFF};
    run_pkt(1'b1, "FF");
    check("FF bit count", cap_len, 17);
    check("FF stream", cap[31:0], 32'h0001DF80);

    pkt = {8'hFC};
    run_pkt(1'b1, "FC");
    check("FC bit count", cap_len, 17);
    check("FC stream", cap[31:0], 32'h0000FC80);

    pkt = {8'h00, 8'h00, 8'h00};
    run_pkt(1'b1, "3x00");
    check("3x00 bit count", cap_len, 32);
    check("3x00 stream", cap[31:0], 32'h00000080);

    pkt = {8'h12};
    run_pkt(1'b0, "underrun");
    check("underrun bit count", cap_len, 16);
    check("underrun stream", cap[31:0], 32'h00001280);

    // reset during the third data bit of a two-byte packet
    tx_valid = 1'b1; tx_data = 8'h3C; tx_last = 1'b0;
    @(posedge clk); #1;
    tx_data = 8'h5A; tx_last = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    check("mid-pkt out_valid before rst", out_valid, 1'b1);
    check("mid-pkt tx_busy before rst", tx_busy, 1'b1);
    rst = 1'b0;
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst tx_busy", tx_busy, 1'b0);
    check("rst tx_error", tx_error, 1'b0);
    check("rst tx_ready", tx_ready, 1'b0);
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    @(negedge clk);
    check("rst held tx_error", tx_error, 1'b0);
    check("rst held serial_out", serial_out, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;

    pkt = {8'hA5};
    run_pkt(1'b1, "A5 after rst");
    check("A5 after rst bit count", cap_len, 16);
    check("A5 after rst stream", cap[31:0], 32'h0000A580);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Upstream feeder for the NRZI line encoder. Accepts packet bytes over a valid/ready handshake, prepends SYNC, shifts data LSB-first at one bit per clk, and inserts USB stuff bits.
- Drives the encoder's serial data and data-valid inputs directly.
- Enforces a minimum idle gap between packets. Aborts cleanly on byte underrun.

Parameters:
- SYNC_PATTERN, 8'h80, SYNC byte, sent LSB-first: 0000_0001.
- IFG_CYCLES, 4, minimum cycles with out_valid=0 after a packet end or abort (>=1).

Ports:
- clk  input  1  bit clock; one serial bit per rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_data  input  8  packet byte.
- tx_valid  input  1  tx_data/tx_last valid.
- tx_last  input  1  marks the final byte of the packet.
- tx_ready  output  1  byte accepted on a cycle with tx_valid & tx_ready.
- serial_out  output  1  bit to the NRZI encoder serial input.
- out_valid  output  1  to the NRZI encoder data-valid input.
- tx_busy  output  1  high in any state other than IDLE.
- tx_error  output  1  one-cycle pulse on underrun abort.

Behaviour:
- All outputs are registered.
- Reset values (rst low, async): state=IDLE, serial_out=0, out_valid=0, tx_busy=0, tx_error=0, hold empty, ones_cnt=0, gap counter=0. tx_ready=0 while rst is low.
- Datapath:
  - 1-deep hold register {data, last}.
  - 8-bit shifter with 3-bit bit index.
  - 3-bit ones_cnt.
  - last_seen flag: a byte with tx_last has been accepted this packet.
- tx_ready = rst & ~hold_full & ~last_seen & (state != GAP).
- States:
  - IDLE: out_valid=0. An accept moves to SYNC next cycle. The byte goes to hold; the shifter is loaded with SYNC_PATTERN.
  - SYNC: emit the 8 SYNC bits. Stuffing counting applies; SYNC exits with ones_cnt=1. At the bit-7 boundary, go to DATA.
  - DATA: emit the shifter LSB each cycle.
  - STUFF: emit 0 for exactly one cycle. ones_cnt=0, the shifter does not advance. Then return to the interrupted flow: the next data bit, or the byte-boundary handling.
  - GAP: out_valid=0 for IFG_CYCLES cycles, then IDLE.
- ones_cnt: on an emitted 1, increment; on an emitted 0 (data or stuff), clear. When an emitted 1 makes ones_cnt=6, the next cycle is STUFF.
- Byte boundary (after bit 7 and any pending STUFF):
  - If the finished byte was last: go to GAP. A trailing stuff bit is still emitted first.
  - Else if hold is full: load the shifter from hold, clear hold, continue with no bubble.
  - Else (underrun): out_valid=0 next cycle, tx_error pulses 1 cycle, go to GAP, clear last_seen.
- Latency:
  - Accept at cycle N gives the first SYNC bit with out_valid=1 at N+1.
  - out_valid stays 1 continuously from the first SYNC bit to the final bit, stuff bits included.
- Simultaneous events: a hold load and a shifter pull from hold in the same cycle are legal. The pull empties hold, the load refills it in the same edge.
- Reset mid-packet: all state clears immediately. out_valid drops asynchronously. No tx_error.
- GAP and IDLE hold serial_out=0.

Test Plan:
- Single byte 0xA5, last=1 -> accept at cycle 0. Cycles 1-16 have out_valid=1 with serial 0,0,0,0,0,0,0,1,1,0,1,0,0,1,0,1. Then out_valid=0 for 4 cycles, tx_ready=1 again in IDLE.
- Byte 0xFF, last=1 -> 17 valid bits: SYNC, then 1,1,1,1,1, stuff 0, 1,1,1. No trailing stuff.
- Byte 0xFC, last=1 -> bits after SYNC: 0,0,1,1,1,1,1,1, then a trailing stuff 0. 17 valid bits, then GAP.
- Three bytes 0x00,0x00,0x00 (last on the third), tx_valid held high -> 32 contiguous valid bits, no bubbles. tx_ready pulses once per byte, tx_error=0.
- Byte 0x12, last=0, no further tx_valid -> 16 valid bits, then out_valid=0 and tx_error=1 for exactly one cycle. GAP of 4 cycles, then IDLE.
- rst low during the 3rd data bit of a 2-byte packet -> out_valid=0 and tx_busy=0 immediately, tx_error stays 0. After release, a new 0xA5 packet reproduces the first scenario exactly.
